// File: rtl/jt49_dcrm_pkg.sv
// Shared FSM encoding and default widths for the DC-removal stage.
// No logic here. The states are sequenced CLR -> IDLE -> RD -> UPD -> OUT -> IDLE.
package jt49_dcrm_pkg;

    localparam int DEF_DW = 10;
    localparam int DEF_AW = 6;

    typedef enum logic [2:0] {
        ST_CLR  = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_UPD  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/jt49_dcrm_ram.sv
// Single-port 2^AW x DW sample history RAM with a registered read (1 clk latency).
// Has no reset, so it maps onto block or distributed RAM. It applies no backpressure.
module jt49_dcrm_ram
    import jt49_dcrm_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdat,
    output logic [DW-1:0] rdat
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdat_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdat;
        end
        rdat_q <= mem[addr];
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/jt49_dcrm.sv
// DC removal: dout = din - mean(last 2^AW), 3 clk cen->valid, cen while busy dropped + lost set.
// `JT49_DCRM_SAT_EN` selects a saturated unity-gain output; the default is a half-gain output.
module jt49_dcrm
    import jt49_dcrm_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic [DW-1:0]        din,
    output logic signed [DW-1:0] dout,
    output logic                 valid,
    output logic                 busy,
    output logic                 lost
);

    localparam logic [AW-1:0] PTR_LAST = '1;

    state_t                 state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [DW+AW-1:0]       acc_q, acc_d;
    logic [DW-1:0]          smp_q, smp_d;
    logic signed [DW-1:0]   dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   lost_q, lost_d;

    logic                   ram_we;
    logic [DW-1:0]          ram_wdat;
    logic [DW-1:0]          ram_rdat;

    logic [DW-1:0]          mean;
    logic signed [DW:0]     diff;
    logic signed [DW-1:0]   cond;

    jt49_dcrm_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ptr_q),
        .wdat (ram_wdat),
        .rdat (ram_rdat)
    );

    // acc always equals the sum of the buffer, so its top DW bits are the window mean
    always_comb begin
        mean = acc_q[DW+AW-1:AW];
        diff = $signed({1'b0, smp_q}) - $signed({1'b0, mean});
`ifdef JT49_DCRM_SAT_EN
        if (diff[DW] != diff[DW-1]) begin
            cond = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            cond = diff[DW-1:0];
        end
`else
        cond = diff[DW:1];
`endif
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        acc_d    = acc_q;
        smp_d    = smp_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        lost_d   = lost_q | (cen && (state_q != ST_IDLE));
        ram_we   = 1'b0;
        ram_wdat = smp_q;

        case (state_q)
            ST_CLR: begin
                ram_we   = 1'b1;
                ram_wdat = '0;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cen) begin
                    smp_d   = din;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_UPD;
            end
            ST_UPD: begin
                // ram_rdat holds the oldest sample, which is the one being replaced
                ram_we  = 1'b1;
                acc_d   = acc_q + {{AW{1'b0}}, smp_q} - {{AW{1'b0}}, ram_rdat};
                ptr_d   = ptr_q + 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                dout_d  = cond;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLR;
            ptr_q   <= '0;
            acc_q   <= '0;
            smp_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            smp_q   <= smp_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign busy  = (state_q != ST_IDLE);
    assign lost  = lost_q;

endmodule

// File: tb/tb_jt49_dcrm.sv
// Randomised bench for jt49_dcrm (DW=10, AW=6) checked against a sliding-window mean model.
module tb_jt49_dcrm;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cen = 1'b0;
    logic [9:0]        din = '0;
    logic signed [9:0] dout;
    logic              valid;
    logic              busy;
    logic              lost;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    jt49_dcrm #(.DW(10), .AW(6)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .din   (din),
        .dout  (dout),
        .valid (valid),
        .busy  (busy),
        .lost  (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a window of the last 64 accepted samples; output = sample - floor(sum/64)
    int hist [64];
    int wp;
    int clr_left;
    int busy_left;
    int pend_dout, pend_sum;
    int m_dout, m_valid, m_lost, m_acc;

    function automatic int hist_sum();
        int s = 0;
        for (int i = 0; i < 64; i++) s += hist[i];
        return s;
    endfunction

    function automatic int cond_fn(input int smp, input int sum);
        int d;
        d = smp - (sum / 64);
`ifdef JT49_DCRM_SAT_EN
        if (d > 511) d = 511;
        if (d < -512) d = -512;
        return d;
`else
        return d >>> 1;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) hist[i] <= 0;
            wp        <= 0;
            clr_left  <= 64;
            busy_left <= 0;
            m_dout    <= 0;
            m_valid   <= 0;
            m_lost    <= 0;
            m_acc     <= 0;
        end else begin
            m_valid <= 0;
            if (clr_left > 0) begin
                clr_left <= clr_left - 1;
                if (cen) m_lost <= 1;
            end else if (busy_left > 0) begin
                if (cen) m_lost <= 1;
                busy_left <= busy_left - 1;
                if (busy_left == 1) begin
                    m_valid <= 1;
                    m_dout  <= pend_dout;
                    m_acc   <= pend_sum;
                end
            end else if (cen) begin
                hist[wp]  <= int'(din);
                wp        <= (wp + 1) % 64;
                pend_sum  <= hist_sum() - hist[wp] + int'(din);
                pend_dout <= cond_fn(int'(din), hist_sum() - hist[wp] + int'(din));
                busy_left <= 3;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", int'(valid), m_valid);
            check("dout", int'(dout), m_dout);
            check("busy", int'(busy), int'((clr_left > 0) || (busy_left > 0)));
            check("lost", int'(lost), m_lost);
            if (m_valid != 0) check("acc", int'(u_dut.acc_q), m_acc);
        end
    end

    // Entered and left at #1 after a rising edge; the next cen lands `gap` edges later.
    task automatic send(input int v, input int gap);
        cen = 1'b1;
        din = 10'(v);
        @(posedge clk); #1;
        cen = 1'b0;
        for (int i = 1; i < gap; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v, r;
`ifdef JT49_DCRM_SAT_EN
        localparam int EXP_FIRST = 296;
        localparam int EXP_HI    = 511;
        localparam int EXP_LO    = -512;
`else
        localparam int EXP_FIRST = 148;
        localparam int EXP_HI    = 504;
        localparam int EXP_LO    = -504;
`endif
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_busy", int'(busy), 1);
        check("rst_dout", int'(dout), 0);
        rst_n = 1'b1;
        count_busy(n);
        check("clr_cycles", n, 64);

        send(300, 4);
        check("first_300_dout", int'(dout), EXP_FIRST);
        check("first_300_acc", int'(u_dut.acc_q), 300);
        repeat (63) send(300, 4);
        check("win_300_dout", int'(dout), 0);
        check("win_300_acc", int'(u_dut.acc_q), 19200);
        repeat (3) send(300, 5);
        check("steady_300_dout", int'(dout), 0);

        send(500, 2);
        send(77, 5);
        check("lost_set", int'(lost), 1);
        check("acc_after_drop", int'(u_dut.acc_q), 19400);

        repeat (150) begin
            r = $urandom_range(0, 9);
            v = (r == 0) ? 0 : (r == 1) ? 1023 : $urandom_range(0, 1023);
            send(v, $urandom_range(2, 7));
        end
        repeat (6) begin @(posedge clk); #1; end

        cen = 1'b1; din = 10'd5;
        @(posedge clk); #1;
        cen = 1'b0;
        @(posedge clk); #1;
        check("upd_busy", int'(busy), 1);
        rst_n = 1'b0;
        #2;
        check("midrst_lost", int'(lost), 0);
        check("midrst_valid", int'(valid), 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        count_busy(n);
        check("reclr_cycles", n, 64);

        send(1023, 4);
        check("step_up_dout", int'(dout), EXP_HI);
        repeat (63) send(1023, 4);
        send(0, 4);
        check("step_down_dout", int'(dout), EXP_LO);
        check("step_down_acc", int'(u_dut.acc_q), 64449);

        repeat (4) begin @(posedge clk); #1; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
